ysyx_wb_arb: RTL and testbench



---
 rtl/ysyx_wb_arb_pkg.sv | 12 +
 rtl/ysyx_wb_fifo.sv | 53 +++++
 rtl/ysyx_wb_arb.sv | 107 ++++++++++
 tb/tb_ysyx_wb_arb.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ysyx_wb_arb_pkg.sv
// Shared constants for the writeback arbiter: default widths and source encodings.
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

package ysyx_wb_arb_pkg;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_IOQ = 1'b1;
endpackage

// File: rtl/ysyx_wb_fifo.sv
// Small power-of-two FIFO holding one writeback source's pending results.
module ysyx_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= din_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/ysyx_wb_arb.sv
// Round-robin arbiter merging ALU and in-order-queue writebacks into one registered port.
module ysyx_wb_arb
  import ysyx_wb_arb_pkg::*;
#(
  parameter int XLEN      = `YSYX_XLEN,
  parameter int ROB_SIZE  = `YSYX_ROB_SIZE,
  parameter int BUF_DEPTH = 2,
  localparam int TW = $clog2(ROB_SIZE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipe,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [TW-1:0]   s0_dest,
  input  logic [XLEN-1:0] s0_result,
  input  logic [XLEN-1:0] s0_npc,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [TW-1:0]   s1_dest,
  input  logic [XLEN-1:0] s1_result,
  input  logic [XLEN-1:0] s1_npc,
  output logic            wb_valid,
  output logic [TW-1:0]   wb_dest,
  output logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] wb_npc,
  output logic            wb_src
);
  localparam int PW = TW + 2 * XLEN;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [PW-1:0] head0, head1, win;
  logic [CW-1:0] cnt0, cnt1;
  logic          ne0, ne1, push0, push1, pop0, pop1, grant, gsrc;

  logic            wb_valid_q, wb_valid_d, wb_src_q, wb_src_d, last_q, last_d;
  logic [TW-1:0]   wb_dest_q, wb_dest_d;
  logic [XLEN-1:0] wb_result_q, wb_result_d, wb_npc_q, wb_npc_d;

  assign s0_ready = (cnt0 < FULL);
  assign s1_ready = (cnt1 < FULL);
  assign push0    = s0_valid && s0_ready && !flush_pipe;
  assign push1    = s1_valid && s1_ready && !flush_pipe;
  assign ne0      = (cnt0 != '0);
  assign ne1      = (cnt1 != '0);

  ysyx_wb_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(PW)) u_fifo0 (
    .clock(clock), .reset(reset), .flush_i(flush_pipe), .push_i(push0), .pop_i(pop0),
    .din_i({s0_dest, s0_result, s0_npc}), .head_o(head0), .count_o(cnt0)
  );

  ysyx_wb_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(PW)) u_fifo1 (
    .clock(clock), .reset(reset), .flush_i(flush_pipe), .push_i(push1), .pop_i(pop1),
    .din_i({s1_dest, s1_result, s1_npc}), .head_o(head1), .count_o(cnt1)
  );

  always_comb begin
    grant       = (ne0 || ne1) && !flush_pipe;
    gsrc        = (ne0 && ne1) ? ~last_q : (ne1 ? SRC_IOQ : SRC_ALU);
    pop0        = grant && (gsrc == SRC_ALU);
    pop1        = grant && (gsrc == SRC_IOQ);
    win         = (gsrc == SRC_IOQ) ? head1 : head0;
    wb_valid_d  = grant;
    wb_src_d    = wb_src_q;
    wb_dest_d   = wb_dest_q;
    wb_result_d = wb_result_q;
    wb_npc_d    = wb_npc_q;
    last_d      = last_q;
    if (flush_pipe) begin
      last_d = SRC_IOQ;
    end else if (grant) begin
      {wb_dest_d, wb_result_d, wb_npc_d} = win;
      wb_src_d = gsrc;
      last_d   = gsrc;
    end
  end

  // last_q resets to the IOQ encoding so the ALU side wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_q  <= 1'b0;
      wb_src_q    <= SRC_ALU;
      wb_dest_q   <= '0;
      wb_result_q <= '0;
      wb_npc_q    <= '0;
      last_q      <= SRC_IOQ;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_src_q    <= wb_src_d;
      wb_dest_q   <= wb_dest_d;
      wb_result_q <= wb_result_d;
      wb_npc_q    <= wb_npc_d;
      last_q      <= last_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_src    = wb_src_q;
  assign wb_dest   = wb_dest_q;
  assign wb_result = wb_result_q;
  assign wb_npc    = wb_npc_q;

  // Destination 0 is reserved; a valid writeback must name a real ROB slot.
  a_s0_dest: assert property (@(posedge clock) disable iff (!reset) s0_valid |-> (s0_dest != '0));
  a_s1_dest: assert property (@(posedge clock) disable iff (!reset) s1_valid |-> (s1_dest != '0));
endmodule

// File: tb/tb_ysyx_wb_arb.sv
// Directed table-driven bench for the writeback arbiter, plus async-reset sequence.
module tb_ysyx_wb_arb;
  localparam int XLEN = 32;
  localparam int TW   = 5;

  logic            clock = 1'b0, reset = 1'b0, flush_pipe = 1'b0;
  logic            s0_valid = 1'b0, s1_valid = 1'b0, s0_ready, s1_ready;
  logic [TW-1:0]   s0_dest = '0, s1_dest = '0, wb_dest;
  logic [XLEN-1:0] s0_result = '0, s1_result = '0, wb_result, wb_npc;
  logic            wb_valid, wb_src;

  // Bench convention: npc is always result + 0x1000.
  wire [XLEN-1:0] s0_npc = s0_result + 32'h1000;
  wire [XLEN-1:0] s1_npc = s1_result + 32'h1000;

  ysyx_wb_arb #(.XLEN(XLEN), .ROB_SIZE(16), .BUF_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .flush_pipe(flush_pipe),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_dest(s0_dest), .s0_result(s0_result), .s0_npc(s0_npc),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_dest(s1_dest), .s1_result(s1_result), .s1_npc(s1_npc),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc), .wb_src(wb_src)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic fl; logic v0; logic [4:0] d0; logic [31:0] r0;
    logic v1; logic [4:0] d1; logic [31:0] r1;
    logic er0; logic er1; logic ewv; logic [4:0] ed; logic [31:0] eres; logic [31:0] enpc; logic esrc;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic fl, input logic v0, input logic [4:0] d0, input logic [31:0] r0,
                     input logic v1, input logic [4:0] d1, input logic [31:0] r1,
                     input logic er0, input logic er1, input logic ewv, input logic [4:0] ed,
                     input logic [31:0] eres, input logic [31:0] enpc, input logic esrc);
    vec_t v;
    v.fl = fl; v.v0 = v0; v.d0 = d0; v.r0 = r0; v.v1 = v1; v.d1 = d1; v.r1 = r1;
    v.er0 = er0; v.er1 = er1; v.ewv = ewv; v.ed = ed; v.eres = eres; v.enpc = enpc; v.esrc = esrc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v0, input logic [4:0] d0, input logic [31:0] r0,
                       input logic v1, input logic [4:0] d1, input logic [31:0] r1);
    flush_pipe = fl; s0_valid = v0; s0_dest = d0; s0_result = r0;
    s1_valid = v1; s1_dest = d1; s1_result = r1;
  endtask

  task automatic check_out(input string tag, input logic er0, input logic er1, input logic ewv,
                           input logic [4:0] ed, input logic [31:0] eres, input logic [31:0] enpc,
                           input logic esrc);
    chk({tag, " s0_ready"},  64'(s0_ready),  64'(er0));
    chk({tag, " s1_ready"},  64'(s1_ready),  64'(er1));
    chk({tag, " wb_valid"},  64'(wb_valid),  64'(ewv));
    chk({tag, " wb_dest"},   64'(wb_dest),   64'(ed));
    chk({tag, " wb_result"}, 64'(wb_result), 64'(eres));
    chk({tag, " wb_npc"},    64'(wb_npc),    64'(enpc));
    chk({tag, " wb_src"},    64'(wb_src),    64'(esrc));
  endtask

  task automatic step(input string tag, input logic er0, input logic er1, input logic ewv,
                      input logic [4:0] ed, input logic [31:0] eres, input logic [31:0] enpc,
                      input logic esrc);
    @(posedge clock);
    #1;
    check_out(tag, er0, er1, ewv, ed, eres, enpc, esrc);
  endtask

  initial begin
    // single source
    add(0, 1,3,'h11, 0,0,0,     1,1,0, 0,'h00,'h0000,0);
    add(0, 0,0,0,    0,0,0,     1,1,1, 3,'h11,'h1011,0);
    add(0, 0,0,0,    0,0,0,     1,1,0, 3,'h11,'h1011,0);
    // flush to re-prefer source 0, then contention
    add(1, 1,5,'h55, 0,0,0,     1,1,0, 3,'h11,'h1011,0);
    add(0, 1,1,'hA1, 1,5,'hB1,  1,1,0, 3,'h11,'h1011,0);
    add(0, 1,2,'hA2, 1,6,'hB2,  1,0,1, 1,'hA1,'h10A1,0);
    add(0, 1,3,'hA3, 1,7,'hB3,  0,1,1, 5,'hB1,'h10B1,1);
    add(0, 1,4,'hA4, 1,7,'hB3,  1,0,1, 2,'hA2,'h10A2,0);
    add(0, 1,4,'hA4, 1,8,'hB4,  0,1,1, 6,'hB2,'h10B2,1);
    add(0, 0,0,0,    1,8,'hB4,  1,0,1, 3,'hA3,'h10A3,0);
    add(0, 0,0,0,    0,0,0,     1,1,1, 7,'hB3,'h10B3,1);
    add(0, 0,0,0,    0,0,0,     1,1,1, 4,'hA4,'h10A4,0);
    add(0, 0,0,0,    0,0,0,     1,1,1, 8,'hB4,'h10B4,1);
    add(0, 0,0,0,    0,0,0,     1,1,0, 8,'hB4,'h10B4,1);
    // s1 fills while s0 streams
    add(0, 1,1,'h21, 1,9,'h31,  1,1,0, 8,'hB4,'h10B4,1);
    add(0, 1,2,'h22, 1,10,'h32, 1,0,1, 1,'h21,'h1021,0);
    add(0, 1,3,'h23, 0,0,0,     0,1,1, 9,'h31,'h1031,1);
    add(0, 1,4,'h24, 0,0,0,     1,1,1, 2,'h22,'h1022,0);
    add(0, 1,4,'h24, 0,0,0,     0,1,1, 10,'h32,'h1032,1);
    add(0, 0,0,0,    0,0,0,     1,1,1, 3,'h23,'h1023,0);
    add(0, 0,0,0,    0,0,0,     1,1,1, 4,'h24,'h1024,0);
    add(0, 0,0,0,    0,0,0,     1,1,0, 4,'h24,'h1024,0);
    // flush with both FIFOs occupied and same-cycle inputs
    add(0, 1,1,'h41, 1,5,'h51,  1,1,0, 4,'h24,'h1024,0);
    add(0, 1,2,'h42, 1,6,'h52,  0,1,1, 5,'h51,'h1051,1);
    add(1, 1,3,'h43, 1,7,'h53,  1,1,0, 5,'h51,'h1051,1);
    add(0, 0,0,0,    0,0,0,     1,1,0, 5,'h51,'h1051,1);
    add(0, 0,0,0,    1,8,'h58,  1,1,0, 5,'h51,'h1051,1);
    add(0, 0,0,0,    0,0,0,     1,1,1, 8,'h58,'h1058,1);
    add(0, 0,0,0,    0,0,0,     1,1,0, 8,'h58,'h1058,1);

    #12;
    check_out("reset", 1, 1, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].v0, vecs[i].d0, vecs[i].r0, vecs[i].v1, vecs[i].d1, vecs[i].r1);
      step($sformatf("row%0d", i), vecs[i].er0, vecs[i].er1, vecs[i].ewv, vecs[i].ed,
           vecs[i].eres, vecs[i].enpc, vecs[i].esrc);
    end

    // async reset mid-stream: first leave source 1 as the preferred one
    drive(0, 1,1,'h61, 0,0,0);
    step("ar0", 1,1,0, 8,'h58,'h1058,1);
    drive(0, 0,0,0, 0,0,0);
    step("ar1", 1,1,1, 1,'h61,'h1061,0);
    drive(0, 1,2,'h62, 1,3,'h63);
    step("ar2", 1,1,0, 1,'h61,'h1061,0);
    drive(0, 0,0,0, 0,0,0);
    #2;
    reset = 1'b0;
    #1;
    check_out("ar_async", 1,1,0, 0,0,0,0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1,4,'h64, 1,5,'h65);
    step("ar3", 1,1,0, 0,0,0,0);
    drive(0, 0,0,0, 0,0,0);
    step("ar4", 1,1,1, 4,'h64,'h1064,0);
    step("ar5", 1,1,1, 5,'h65,'h1065,1);
    step("ar6", 1,1,0, 5,'h65,'h1065,1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
